led_anim_seq: RTL and testbench

//   Sequencer for the LED animation pattern decoders (5-bit frame index -> 7-bit active-low pattern).

---
 rtl/led_anim_pkg.sv | 26 ++
 rtl/led_anim_prescaler.sv | 42 ++++
 rtl/led_anim_seq.sv | 135 +++++++++++++
 tb/tb_led_anim_seq.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_anim_pkg.sv
// Shared definitions for the LED animation sequencer.
//   ST_*     FSM state encoding (legacy-compatible constants)
//   MODE_*   playback mode codes as presented on the mode input
//   LED_OFF  active-low all-off pattern driven by the LED mux when blank=1
//   frame_period() clocks per frame step for a given speed setting
package led_anim_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam logic [1:0] MODE_ONESHOT  = 2'b00;
    localparam logic [1:0] MODE_LOOP     = 2'b01;
    localparam logic [1:0] MODE_PINGPONG = 2'b10;

    localparam logic [6:0] LED_OFF = 7'b1111111;

    // Period shrinks by powers of two with speed; never below one clock.
    function automatic logic [31:0] frame_period(input logic [31:0] div,
                                                 input logic [2:0]  speed);
        logic [31:0] p;
        p = div >> speed;
        return (p == '0) ? 32'd1 : p;
    endfunction

endpackage

// File: rtl/led_anim_prescaler.sv
// Frame-rate prescaler for led_anim_seq.
//   clk, rst_n  clock / async active-low reset
//   clear       zero the count (restart / abort)
//   enable      count this cycle (low freezes the count)
//   speed       rate select, period = max(1, TICK_DIV >> speed)
//   tick        combinational: the enabled cycle that completes a period
module led_anim_prescaler
    import led_anim_pkg::*;
#(
    parameter int unsigned TICK_DIV = 5_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       enable,
    input  logic [2:0] speed,
    output logic       tick
);

    localparam int unsigned CW = $clog2(TICK_DIV);

    logic [CW-1:0] count;
    logic [31:0]   period;

    // Compare with >= so a speed increase mid-period cannot overshoot
    // the new terminal count and stall for a counter wrap.
    always_comb begin
        period = frame_period(32'(TICK_DIV), speed);
        tick   = enable && (32'(count) >= (period - 32'd1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= tick ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/led_anim_seq.sv
// LED animation sequencer: frame index generation and pattern select.
//   clk, rst_n   clock / async active-low reset
//   start, stop  1-cycle pulses: (re)start playback / abort to idle
//   pause        level: freeze playback while high
//   dir, mode    direction and playback mode, latched at start
//   speed        frame rate select (live)
//   pat_sel      pattern to play, latched at start
//   frame, pat   frame index and latched pattern select to decoders/mux
//   blank        force LEDs off; busy: RUN or HOLD
//   step, done   1-cycle pulses: frame changed / one-shot completed
module led_anim_seq #(
    parameter int unsigned TICK_DIV   = 5_000_000,
    parameter int unsigned NUM_FRAMES = 32,
    parameter int unsigned PAT_W      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic [2:0]       speed,
    input  logic [PAT_W-1:0] pat_sel,
    output logic [4:0]       frame,
    output logic [PAT_W-1:0] pat,
    output logic             blank,
    output logic             busy,
    output logic             step,
    output logic             done
);

    import led_anim_pkg::*;

    localparam logic [4:0] LAST = 5'(NUM_FRAMES - 1);

    logic [1:0] state;
    logic [1:0] mode_q;
    logic       dir_q;
    logic       pdir;      // ping-pong travel direction, 1 = down
    logic       tick;
    logic       pre_en;
    logic [4:0] nxt_frame;
    logic       nxt_pdir;
    logic       os_end;

    // Start/stop in the same cycle as a due step win: the prescaler is
    // neither advanced nor allowed to tick, and is cleared instead.
    assign pre_en = (state != ST_IDLE) && !pause && !start && !stop;

    led_anim_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (start | stop),
        .enable (pre_en),
        .speed  (speed),
        .tick   (tick)
    );

    always_comb begin
        nxt_frame = frame;
        nxt_pdir  = pdir;
        os_end    = 1'b0;
        case (mode_q)
            MODE_ONESHOT: begin
                if (dir_q) begin
                    if (frame == '0) os_end = 1'b1;
                    else             nxt_frame = frame - 5'd1;
                end else begin
                    if (frame == LAST) os_end = 1'b1;
                    else               nxt_frame = frame + 5'd1;
                end
            end
            MODE_PINGPONG: begin
                nxt_frame = pdir ? frame - 5'd1 : frame + 5'd1;
                if (nxt_frame == '0 || nxt_frame == LAST) nxt_pdir = !pdir;
            end
            default: begin
                if (dir_q) nxt_frame = (frame == '0)  ? LAST : frame - 5'd1;
                else       nxt_frame = (frame == LAST) ? '0  : frame + 5'd1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            frame  <= '0;
            pat    <= '0;
            blank  <= 1'b1;
            busy   <= 1'b0;
            step   <= 1'b0;
            done   <= 1'b0;
            mode_q <= MODE_ONESHOT;
            dir_q  <= 1'b0;
            pdir   <= 1'b0;
        end else begin
            step <= 1'b0;
            done <= 1'b0;
            if (stop) begin
                state <= ST_IDLE;
                frame <= '0;
                blank <= 1'b1;
                busy  <= 1'b0;
            end else if (start) begin
                state  <= ST_RUN;
                mode_q <= mode;
                dir_q  <= dir;
                pdir   <= dir;
                pat    <= pat_sel;
                frame  <= dir ? LAST : '0;
                blank  <= 1'b0;
                busy   <= 1'b1;
            end else if (state != ST_IDLE) begin
                state <= pause ? ST_HOLD : ST_RUN;
                if (tick) begin
                    if (os_end) begin
                        state <= ST_IDLE;
                        frame <= '0;
                        blank <= 1'b1;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        frame <= nxt_frame;
                        pdir  <= nxt_pdir;
                        step  <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_led_anim_seq.sv
// Self-checking bench for led_anim_seq (TICK_DIV=4). Main instance uses
// 32 frames; a second instance with 4 frames covers ping-pong ends.
module tb_led_anim_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       pause = 1'b0;
    logic       dir = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [2:0] speed = 3'd0;
    logic [3:0] pat_sel = 4'd0;

    logic [4:0] frame, frame_pp;
    logic [3:0] pat, pat_pp;
    logic       blank, busy, step, done;
    logic       blank_pp, busy_pp, step_pp, done_pp;

    typedef struct {
        logic [4:0] frame;
        int         gap;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    led_anim_seq #(.TICK_DIV(4), .NUM_FRAMES(32), .PAT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pause(pause),
        .dir(dir), .mode(mode), .speed(speed), .pat_sel(pat_sel),
        .frame(frame), .pat(pat), .blank(blank), .busy(busy),
        .step(step), .done(done)
    );

    led_anim_seq #(.TICK_DIV(4), .NUM_FRAMES(4), .PAT_W(4)) dut_pp (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pause(pause),
        .dir(dir), .mode(mode), .speed(speed), .pat_sel(pat_sel),
        .frame(frame_pp), .pat(pat_pp), .blank(blank_pp), .busy(busy_pp),
        .step(step_pp), .done(done_pp)
    );

    // Cycles (sampled 1 time unit after each rising edge) until step is seen.
    task automatic wait_step(input bit pp, input int limit, output int gap, output bit seen);
        gap  = 0;
        seen = 1'b0;
        while (!seen && gap < limit) begin
            @(posedge clk); #1;
            gap++;
            if ((pp ? step_pp : step) === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        @(posedge clk); #1;
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (frame !== 5'd0) begin errors++; $display("FAIL reset_frame got=%0d exp=0", frame); end
        checks++; if (pat !== 4'd0) begin errors++; $display("FAIL reset_pat got=%0d exp=0", pat); end
        checks++; if (blank !== 1'b1) begin errors++; $display("FAIL reset_blank got=%b exp=1", blank); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (step !== 1'b0) begin errors++; $display("FAIL reset_step got=%b exp=0", step); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        rst_n = 1'b1;
    endtask

    task automatic test_loop_up();
        exp_t e;
        int   g;
        bit   s;
        mode = 2'b01; dir = 1'b0; speed = 3'd0; pat_sel = 4'd5;
        pulse_start();
        checks++; if (frame !== 5'd0) begin errors++; $display("FAIL loop_load_frame got=%0d exp=0", frame); end
        checks++; if (busy !== 1'b1 || blank !== 1'b0) begin errors++; $display("FAIL loop_load_flags busy=%b blank=%b exp busy=1 blank=0", busy, blank); end
        checks++; if (pat !== 4'd5) begin errors++; $display("FAIL loop_load_pat got=%0d exp=5", pat); end
        checks++; if (step !== 1'b0) begin errors++; $display("FAIL loop_load_step got=%b exp=0", step); end
        for (int i = 1; i <= 33; i++) sb.push_back('{frame: 5'(i % 32), gap: 4});
        while (sb.size() > 0) begin
            e = sb.pop_front();
            wait_step(1'b0, 20, g, s);
            checks++;
            if (!s) begin
                errors++; $display("FAIL loop_step_timeout exp_frame=%0d", e.frame);
            end else begin
                if (frame !== e.frame) begin errors++; $display("FAIL loop_frame got=%0d exp=%0d", frame, e.frame); end
                checks++; if (g !== e.gap) begin errors++; $display("FAIL loop_gap got=%0d exp=%0d", g, e.gap); end
            end
        end
        pulse_stop();
        checks++; if (busy !== 1'b0 || blank !== 1'b1 || frame !== 5'd0) begin errors++; $display("FAIL loop_stop busy=%b blank=%b frame=%0d exp 0/1/0", busy, blank, frame); end
    endtask

    task automatic test_oneshot_down();
        exp_t e;
        int   g;
        bit   s;
        int   k;
        mode = 2'b00; dir = 1'b1; speed = 3'd0;
        pulse_start();
        checks++; if (frame !== 5'd31) begin errors++; $display("FAIL os_load_frame got=%0d exp=31", frame); end
        for (int i = 30; i >= 0; i--) sb.push_back('{frame: 5'(i), gap: 4});
        while (sb.size() > 0) begin
            e = sb.pop_front();
            wait_step(1'b0, 20, g, s);
            checks++;
            if (!s) begin
                errors++; $display("FAIL os_step_timeout exp_frame=%0d", e.frame);
            end else begin
                if (frame !== e.frame) begin errors++; $display("FAIL os_frame got=%0d exp=%0d", frame, e.frame); end
                checks++; if (g !== e.gap) begin errors++; $display("FAIL os_gap got=%0d exp=%0d", g, e.gap); end
            end
        end
        k = 0;
        s = 1'b0;
        while (!s && k < 20) begin
            @(posedge clk); #1;
            k++;
            if (done === 1'b1) s = 1'b1;
            else if (step === 1'b1) begin checks++; errors++; $display("FAIL os_extra_step frame=%0d exp no step", frame); end
        end
        checks++;
        if (!s) begin
            errors++; $display("FAIL os_done_timeout got none exp done");
        end else begin
            if (k !== 4) begin errors++; $display("FAIL os_last_hold got=%0d exp=4", k); end
            checks++; if (frame !== 5'd0 || blank !== 1'b1 || busy !== 1'b0 || step !== 1'b0) begin
                errors++; $display("FAIL os_exit frame=%0d blank=%b busy=%b step=%b exp 0/1/0/0", frame, blank, busy, step);
            end
        end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL os_done_width got=%b exp=0", done); end
    endtask

    task automatic test_pingpong();
        exp_t e;
        int   g;
        bit   s;
        logic [4:0] seq [7];
        seq = '{5'd1, 5'd2, 5'd3, 5'd2, 5'd1, 5'd0, 5'd1};
        mode = 2'b10; dir = 1'b0; speed = 3'd0;
        pulse_start();
        checks++; if (frame_pp !== 5'd0) begin errors++; $display("FAIL pp_load_frame got=%0d exp=0", frame_pp); end
        foreach (seq[i]) sb.push_back('{frame: seq[i], gap: 4});
        while (sb.size() > 0) begin
            e = sb.pop_front();
            wait_step(1'b1, 20, g, s);
            checks++;
            if (!s) begin
                errors++; $display("FAIL pp_step_timeout exp_frame=%0d", e.frame);
            end else begin
                if (frame_pp !== e.frame) begin errors++; $display("FAIL pp_frame got=%0d exp=%0d", frame_pp, e.frame); end
                checks++; if (g !== e.gap) begin errors++; $display("FAIL pp_gap got=%0d exp=%0d", g, e.gap); end
            end
        end
        pulse_stop();
    endtask

    task automatic test_pause();
        int g;
        bit s;
        mode = 2'b01; dir = 1'b0; speed = 3'd0;
        pulse_start();
        repeat (2) @(posedge clk);
        #1;
        pause = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++; if (step !== 1'b0 || frame !== 5'd0 || busy !== 1'b1) begin
                errors++; $display("FAIL pause_hold step=%b frame=%0d busy=%b exp 0/0/1", step, frame, busy);
            end
        end
        pause = 1'b0;
        wait_step(1'b0, 20, g, s);
        checks++;
        if (!s) begin
            errors++; $display("FAIL pause_resume_timeout got none exp step");
        end else begin
            if (g !== 2) begin errors++; $display("FAIL pause_resume_gap got=%0d exp=2", g); end
            checks++; if (frame !== 5'd1) begin errors++; $display("FAIL pause_resume_frame got=%0d exp=1", frame); end
        end
        pulse_stop();
    endtask

    task automatic test_stop_start();
        mode = 2'b01; dir = 1'b0; speed = 3'd0;
        pulse_start();
        repeat (6) @(posedge clk);
        #1;
        stop = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0; start = 1'b0;
        checks++; if (busy !== 1'b0 || blank !== 1'b1 || frame !== 5'd0 || done !== 1'b0) begin
            errors++; $display("FAIL stopstart busy=%b blank=%b frame=%0d done=%b exp 0/1/0/0", busy, blank, frame, done);
        end
        repeat (5) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0 || step !== 1'b0) begin errors++; $display("FAIL stopstart_idle busy=%b step=%b exp 0/0", busy, step); end
    endtask

    task automatic test_speed_clamp();
        exp_t e;
        int   g;
        bit   s;
        mode = 2'b01; dir = 1'b0; speed = 3'd3;
        pulse_start();
        for (int i = 1; i <= 6; i++) sb.push_back('{frame: 5'(i), gap: 1});
        while (sb.size() > 0) begin
            e = sb.pop_front();
            wait_step(1'b0, 10, g, s);
            checks++;
            if (!s) begin
                errors++; $display("FAIL speed_step_timeout exp_frame=%0d", e.frame);
            end else begin
                if (frame !== e.frame) begin errors++; $display("FAIL speed_frame got=%0d exp=%0d", frame, e.frame); end
                checks++; if (g !== e.gap) begin errors++; $display("FAIL speed_gap got=%0d exp=%0d", g, e.gap); end
            end
        end
        pulse_stop();
        speed = 3'd0;
    endtask

    task automatic test_async_reset();
        mode = 2'b01; dir = 1'b0; speed = 3'd0; pat_sel = 4'd9;
        pulse_start();
        repeat (9) @(posedge clk);
        #1;
        checks++; if (frame !== 5'd2) begin errors++; $display("FAIL arst_pre_frame got=%0d exp=2", frame); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (frame !== 5'd0 || pat !== 4'd0 || blank !== 1'b1 || busy !== 1'b0 || step !== 1'b0) begin
            errors++; $display("FAIL arst_now frame=%0d pat=%0d blank=%b busy=%b step=%b exp 0/0/1/0/0", frame, pat, blank, busy, step);
        end
        repeat (3) begin
            @(posedge clk); #1;
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL arst_done got=%b exp=0", done); end
        end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL arst_after busy=%b done=%b exp 0/0", busy, done); end
    endtask

    initial begin
        test_reset();
        test_loop_up();
        test_oneshot_down();
        test_pingpong();
        test_pause();
        test_stop_start();
        test_speed_clamp();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
